// File: rtl/wallace_mul_arbiter.sv
// ---------------------------------------------------------------------------
// wallace_mul_arbiter
//
// Purpose:
//   Shares one external combinational 16x16 Wallace-tree multiplier among
//   NREQ requesters. A round-robin arbiter picks one requester at a time.
//   The winner's operands are registered onto mul_a/mul_b. The multiplier
//   product on mul_p is registered one cycle later. It is then returned on a
//   single valid/ready response channel, tagged with the requester index.
//
// Optional feature:
//   WMUL_ARB_LOCK_EN - when defined, a winner that presented req_lock keeps
//   the highest arbitration priority for the next round. When undefined,
//   req_lock is ignored.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   [NREQ]      per-requester operand valid
//   req_ready  out  [NREQ]      per-requester accept (one-hot or zero)
//   req_a      in   [NREQ*16]   operand A, requester i at [16i+15:16i]
//   req_b      in   [NREQ*16]   operand B, same packing
//   req_lock   in   [NREQ]      keep-priority request
//   mul_a      out  [16]        registered operand A to the multiplier
//   mul_b      out  [16]        registered operand B to the multiplier
//   mul_p      in   [32]        product from the multiplier
//   rsp_valid  out  response valid
//   rsp_ready  in   response accept
//   rsp_data   out  [32]        unsigned product
//   rsp_id     out  [IDW]       owning requester index
//   busy       out  high whenever not IDLE
//   op_count   out  [16]        completed-response counter (wraps)
// ---------------------------------------------------------------------------
module wallace_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*16-1:0] req_a,
  input  logic [NREQ*16-1:0] req_b,
  input  logic [NREQ-1:0]    req_lock,
  output logic [15:0]        mul_a,
  output logic [15:0]        mul_b,
  input  logic [31:0]        mul_p,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy,
  output logic [15:0]        op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [15:0]     mul_a_q,     mul_a_d;
  logic [15:0]     mul_b_q,     mul_b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q,  rsp_data_d;
  logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
  logic [15:0]     op_count_q,  op_count_d;

`ifdef WMUL_ARB_LOCK_EN
  logic            lock_q,      lock_d;
`else
  // req_lock has no function in this build.
  logic            unused_lock_s;
  assign unused_lock_s = ^req_lock;
`endif

  logic            win_found_s;
  logic [IDW-1:0]  win_idx_s;
  logic [15:0]     win_a_s;
  logic [15:0]     win_b_s;
  logic [IDW-1:0]  ptr_inc_s;
  logic [NREQ-1:0] req_ready_s;
  int unsigned     cand_v;

  // Round-robin search: first valid requester at or after rr_ptr, modulo NREQ.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IDW{1'b0}};
    cand_v      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand_v = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_found_s && req_valid[cand_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_v[IDW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_a_s = req_a[int'(win_idx_s)*16 +: 16];
    win_b_s = req_b[int'(win_idx_s)*16 +: 16];
  end

  // Pointer advance past the current owner; NREQ need not be a power of two.
  always_comb begin
    if (rsp_id_q == IDW'(NREQ - 1)) begin
      ptr_inc_s = {IDW{1'b0}};
    end else begin
      ptr_inc_s = rsp_id_q + IDW'(1);
    end
  end

  // Next-state and datapath-load logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    op_count_d  = op_count_q;
    req_ready_s = {NREQ{1'b0}};
`ifdef WMUL_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          req_ready_s[win_idx_s] = 1'b1;
          mul_a_d  = win_a_s;
          mul_b_d  = win_b_s;
          rsp_id_d = win_idx_s;
`ifdef WMUL_ARB_LOCK_EN
          lock_d   = req_lock[win_idx_s];
`endif
          state_d  = ST_EXEC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Operands have been stable on mul_a/mul_b for this whole cycle.
        rsp_data_d  = mul_p;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 16'd1;
`ifdef WMUL_ARB_LOCK_EN
          if (lock_q) begin
            rr_ptr_d = rr_ptr_q;
          end else begin
            rr_ptr_d = ptr_inc_s;
          end
`else
          rr_ptr_d    = ptr_inc_s;
`endif
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= {IDW{1'b0}};
      mul_a_q     <= 16'h0000;
      mul_b_q     <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_id_q    <= {IDW{1'b0}};
      op_count_q  <= 16'h0000;
`ifdef WMUL_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      op_count_q  <= op_count_d;
`ifdef WMUL_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  // The grant must be combinational; it is forced low while reset is held.
  assign req_ready = rst_n ? req_ready_s : {NREQ{1'b0}};
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
module tb_wallace_mul_arbiter;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_lock;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_p;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [15:0] op_count;

  logic [15:0] opa [4];
  logic [15:0] opb [4];

  int checks   = 0;
  int failures = 0;

  // scoreboard: {id, product} pushed at grant, popped at response handshake
  logic [33:0] sb_q [$];
  int          model_ptr = 0;
  int          cur_win   = 0;
  logic        cur_lock  = 1'b0;
  int          exp_ops   = 0;

  always #5 clk = ~clk;

  assign req_a = {opa[3], opa[2], opa[1], opa[0]};
  assign req_b = {opb[3], opb[2], opb[1], opb[0]};
  // external shared multiplier
  assign mul_p = {16'h0000, mul_a} * {16'h0000, mul_b};

  wallace_mul_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_lock(req_lock),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy(busy), .op_count(op_count)
  );

  task automatic monitor();
    logic [33:0] e;
    int w;
    int idx;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_rsp: got id=%0d data=%h, required no response", rsp_id, rsp_data);
          end else begin
            e = sb_q.pop_front();
            if ({rsp_id, rsp_data} !== e) begin
              failures++;
              $display("FAIL sb_rsp: got id=%0d data=%h, required id=%0d data=%h", rsp_id, rsp_data, e[33:32], e[31:0]);
            end
          end
          checks++;
          if (op_count !== 16'(exp_ops)) begin
            failures++;
            $display("FAIL sb_op_count: got %0d, required %0d", op_count, exp_ops);
          end
          exp_ops = (exp_ops + 1) % 65536;
`ifdef WMUL_ARB_LOCK_EN
          if (!cur_lock) model_ptr = (cur_win + 1) % NREQ;
`else
          model_ptr = (cur_win + 1) % NREQ;
`endif
        end
        if (req_ready !== 4'b0000) begin
          w = -1;
          for (int k = 0; k < NREQ; k++) begin
            idx = (model_ptr + k) % NREQ;
            if (w < 0 && req_valid[idx] === 1'b1) w = idx;
          end
          checks++;
          if (w < 0) begin
            failures++;
            $display("FAIL grant_no_valid: got req_ready=%b, required 0000", req_ready);
          end else begin
            if (req_ready !== (4'b0001 << w)) begin
              failures++;
              $display("FAIL grant_winner: got req_ready=%b, required %b", req_ready, 4'b0001 << w);
            end
            sb_q.push_back({2'(w), {16'h0000, opa[w]} * {16'h0000, opb[w]}});
            cur_win  = w;
            cur_lock = req_lock[w];
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = 4'b0000;
    sb_q.delete();
    model_ptr = 0;
    exp_ops = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (req_ready[r] === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && busy === 1'b0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_timeout: got pending=%0d busy=%b, required 0 and 0", sb_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; req_lock = 4'h0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin opa[i] = 16'h1111; opb[i] = 16'h2222; end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++; $display("FAIL reset_req_ready: got %b, required 0000", req_ready);
      end
    end
    @(posedge clk); #1;
    req_valid = 4'b0000; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mul_a !== 16'h0000) begin failures++; $display("FAIL reset_mul_a: got %h, required 0000", mul_a); end
    checks++; if (mul_b !== 16'h0000) begin failures++; $display("FAIL reset_mul_b: got %h, required 0000", mul_b); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL reset_rsp_data: got %h, required 0", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id: got %0d, required 0", rsp_id); end
    checks++; if (op_count !== 16'h0) begin failures++; $display("FAIL reset_op_count: got %0d, required 0", op_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single();
    bit ok;
    @(posedge clk); #1;
    opa[1] = 16'h0003; opb[1] = 16'h0005; rsp_ready = 1'b1; req_valid = 4'b0010;
    wait_grant(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_grant: got no grant, required req_ready[1]"); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_exec: got rsp_valid=%b busy=%b, required 0 1", rsp_valid, busy); end
    checks++; if (mul_a !== 16'h0003 || mul_b !== 16'h0005) begin failures++; $display("FAIL single_operands: got %h %h, required 0003 0005", mul_a, mul_b); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid: got %b, required 1", rsp_valid); end
    checks++; if (rsp_data !== 32'h0000000F || rsp_id !== 2'd1) begin failures++; $display("FAIL single_rsp: got id=%0d data=%h, required 1 0000000f", rsp_id, rsp_data); end
    @(negedge clk);
    checks++; if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL single_after: got op_count=%0d rsp_valid=%b, required 1 0", op_count, rsp_valid); end
  endtask

  task automatic test_contention();
    int ids [4];
    int cyc [4];
    int n;
    do_reset();
    opa[0] = 16'h1234; opb[0] = 16'h0002;
    opa[1] = 16'h00FF; opb[1] = 16'h0101;
    opa[2] = 16'hABCD; opb[2] = 16'h1000;
    opa[3] = 16'h8000; opb[3] = 16'h8000;
    for (int j = 0; j < 4; j++) begin ids[j] = -1; cyc[j] = 0; end
    n = 0;
    rsp_ready = 1'b1; req_valid = 4'hF;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) begin
        for (int k = 0; k < 4; k++) if (req_ready[k] === 1'b1) ids[n] = k;
        cyc[n] = i;
        n++;
      end
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (n != 4) begin failures++; $display("FAIL contention_count: got %0d grants, required 4", n); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (ids[j] != j) begin failures++; $display("FAIL contention_id%0d: got %0d, required %0d", j, ids[j], j); end
      if (j > 0) begin
        checks++;
        if (cyc[j] - cyc[j-1] != 3) begin failures++; $display("FAIL contention_spacing%0d: got %0d, required 3", j, cyc[j] - cyc[j-1]); end
      end
    end
    wait_drain();
  endtask

  task automatic test_extreme();
    logic [15:0] ca [2];
    logic [15:0] cb [2];
    logic [31:0] ce [2];
    int          cr [2];
    bit ok;
    ca = '{16'hFFFF, 16'h0000};
    cb = '{16'hFFFF, 16'hFFFF};
    ce = '{32'hFFFE0001, 32'h00000000};
    cr = '{0, 3};
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      opa[cr[c]] = ca[c]; opb[cr[c]] = cb[c]; rsp_ready = 1'b1;
      req_valid = 4'b0001 << cr[c];
      wait_grant(cr[c], ok);
      checks++; if (!ok) begin failures++; $display("FAIL extreme_grant%0d: got no grant, required grant", c); end
      @(posedge clk); #1;
      req_valid = 4'b0000;
      wait_rsp(ok);
      checks++;
      if (!ok || rsp_data !== ce[c]) begin failures++; $display("FAIL extreme_data%0d: got %h, required %h", c, rsp_data, ce[c]); end
      wait_drain();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] d0;
    logic [1:0]  i0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    opa[0] = 16'h0007; opb[0] = 16'h0009; req_valid = 4'b0001;
    wait_grant(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_grant: got no grant, required req_ready[0]"); end
    @(posedge clk); #1;
    opa[2] = 16'h0011; opb[2] = 16'h0013; req_valid = 4'b0100;
    wait_rsp(ok);
    d0 = rsp_data; i0 = rsp_id;
    checks++; if (!ok || d0 !== 32'h0000003F || i0 !== 2'd0) begin failures++; $display("FAIL bp_rsp: got id=%0d data=%h, required 0 0000003f", i0, d0); end
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== i0) begin failures++; $display("FAIL bp_stable: got v=%b id=%0d data=%h, required 1 %0d %h", rsp_valid, rsp_id, rsp_data, i0, d0); end
      checks++;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_req_ready: got %b, required 0000", req_ready); end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_next_grant: got %b, required 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_drain();
  endtask

  task automatic test_lock();
    int ids [3];
    int expd [3];
    int n;
`ifdef WMUL_ARB_LOCK_EN
    expd = '{0, 0, 0};
`else
    expd = '{0, 1, 0};
`endif
    do_reset();
    opa[0] = 16'h0101; opb[0] = 16'h0003;
    opa[1] = 16'h0202; opb[1] = 16'h0004;
    for (int j = 0; j < 3; j++) ids[j] = -1;
    n = 0;
    rsp_ready = 1'b1; req_lock = 4'b0001; req_valid = 4'b0011;
    for (int i = 0; i < 50 && n < 3; i++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) begin
        for (int k = 0; k < 4; k++) if (req_ready[k] === 1'b1) ids[n] = k;
        n++;
      end
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (ids[j] != expd[j]) begin failures++; $display("FAIL lock_id%0d: got %0d, required %0d", j, ids[j], expd[j]); end
    end
    wait_drain();
    req_lock = 4'b0000;
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(posedge clk); #1;
    rsp_ready = 1'b1; opa[1] = 16'h0010; opb[1] = 16'h0010; req_valid = 4'b0010;
    wait_grant(1, ok);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_drain();
    @(posedge clk); #1;
    opa[3] = 16'h0033; opb[3] = 16'h0044; req_valid = 4'b1000;
    wait_grant(3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_grant: got no grant, required req_ready[3]"); end
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 4'b0000;
    sb_q.delete(); model_ptr = 0; exp_ops = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || op_count !== 16'h0) begin failures++; $display("FAIL rmid_state: got busy=%b op_count=%0d, required 0 0", busy, op_count); end
    checks++; if (mul_a !== 16'h0 || mul_b !== 16'h0 || rsp_data !== 32'h0 || rsp_id !== 2'd0) begin failures++; $display("FAIL rmid_outputs: got %h %h %h %0d, required zeros", mul_a, mul_b, rsp_data, rsp_id); end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_rsp: got rsp_valid=%b, required 0", rsp_valid); end
    end
    @(posedge clk); #1;
    opa[0] = 16'h0005; opb[0] = 16'h0006; opa[2] = 16'h0007; opb[2] = 16'h0008;
    req_valid = 4'b0101;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_ptr: got req_ready=%b, required 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 4'b0000; req_lock = 4'b0000; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin opa[i] = 16'h0000; opb[i] = 16'h0000; end
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_contention();
    test_extreme();
    test_backpressure();
    test_lock();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wallace_mul_arbiter.md
# wallace_mul_arbiter

Shares one combinational 16x16 Wallace-tree multiplier among `NREQ` requesters. Round-robin arbitration selects one request at a time. The block registers the operands that drive the shared multiplier and registers the 32-bit product. It returns the product on a single valid/ready response channel tagged with the requester index. It sits between the requesting datapath blocks and the multiplier instance, which connects externally through `mul_a`/`mul_b`/`mul_p`.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default 2: width of `rsp_id`, equal to clog2(`NREQ`).
- `clk`, in, 1: the single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset; one clock, reset is synchronous and active-low.
- `req_valid`, in, `NREQ`: per-requester operand valid.
- `req_ready`, out, `NREQ`: per-requester accept, one-hot or zero.
- `req_a`, in, `NREQ*16`: operand A of requester i at bits [16i+15:16i].
- `req_b`, in, `NREQ*16`: operand B, same packing as `req_a`.
- `req_lock`, in, `NREQ`: keep-priority request; used only with `WMUL_ARB_LOCK_EN`.
- `mul_a`, out, 16: registered operand A to the shared multiplier.
- `mul_b`, out, 16: registered operand B to the shared multiplier.
- `mul_p`, in, 32: product returned from the multiplier.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: response accept.
- `rsp_data`, out, 32: unsigned product.
- `rsp_id`, out, `IDW`: index of the requester that owns the response.
- `busy`, out, 1: high in every state except IDLE.
- `op_count`, out, 16: completed-response counter.

## Operation
- The state machine has three states: IDLE, EXEC and RESP.
- **IDLE**
  - Search for a winner starting at `rr_ptr`, taking the first i with `req_valid[i]`=1 in increasing index order, modulo `NREQ`.
  - `req_ready[winner]`=1 is driven combinationally in the same cycle. All other `req_ready` bits stay 0.
  - On the edge:
    - `mul_a` <= A of the winner; `mul_b` <= B of the winner.
    - `rsp_id` <= winner index.
    - `lock_q` <= `req_lock[winner]`.
    - Next state is EXEC.
  - With no `req_valid` asserted, stay in IDLE.
- **EXEC**
  - `mul_a`/`mul_b` are stable for the whole cycle.
  - On the edge: `rsp_data` <= `mul_p`, `rsp_valid` <= 1, next state is RESP.
- **RESP**
  - `rsp_valid`, `rsp_data` and `rsp_id` hold until `rsp_valid & rsp_ready`.
  - On that handshake:
    - `rsp_valid` <= 0.
    - `op_count` <= `op_count`+1, wrapping 0xFFFF to 0x0000.
    - `rr_ptr` is updated per Configuration.
    - Next state is IDLE.
- `req_ready` is 0 in EXEC and RESP. Requesters must hold `req_valid`, `req_a` and `req_b` until they are accepted.
- Between operations `mul_a`/`mul_b` hold their last values; there is no zeroing.
- Arithmetic is unsigned. The product is the full 32 bits; no truncation or saturation.
- A requester that drops `req_valid` before grant is not served and leaves no state behind.
- `rr_ptr` wrap: from winner `NREQ-1`, advancing gives 0.

## Timing
- Reset values:
  - State is IDLE; `rr_ptr`=0.
  - `mul_a`=0, `mul_b`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0.
  - `op_count`=0, `busy`=0.
  - `req_ready`=0 during reset.
- Reset mid-operation abandons the operation. No response is produced for an accepted request, and `op_count` is not incremented.
- Latency:
  - Request accepted at edge T: `mul_a`/`mul_b` are valid after T.
  - The product is captured at edge T+1.
  - `rsp_valid`=1 from T+1 to T+2, i.e. in the cycle after EXEC.
- Minimum spacing between accepts is 3 cycles (IDLE, EXEC, RESP with `rsp_ready`=1).
- The shared multiplier must close timing in one cycle, register to register.
- `rsp_ready` held low: the block stays in RESP indefinitely. No new grant is issued and outputs are stable.

## Configuration
- `WMUL_ARB_LOCK_EN` defined:
  - On the RESP handshake, if `lock_q`=1 then `rr_ptr` is unchanged, so the same requester keeps highest priority for the next arbitration.
  - If `lock_q`=0 then `rr_ptr` <= winner+1.
- `WMUL_ARB_LOCK_EN` not defined:
  - `req_lock` is ignored and `lock_q` is not implemented.
  - `rr_ptr` <= winner+1 on every RESP handshake.

## Test plan
- **Single request:** requester 1 only, A=0x0003, B=0x0005, `rsp_ready`=1.
  - Response: `rsp_valid` 2 cycles after accept, `rsp_data`=0x0000000F, `rsp_id`=1, `op_count`=1.
- **Full contention:** all four `req_valid` held high for 4 operations, `rsp_ready`=1.
  - Responses: `rsp_id` sequence 0,1,2,3, each grant 3 cycles apart.
- **Extreme operands:** A=0xFFFF, B=0xFFFF gives `rsp_data`=0xFFFE0001. A=0x0000, B=0xFFFF gives 0x00000000.
- **Backpressure:** hold `rsp_ready`=0 for 10 cycles while requester 2 also asserts valid.
  - Response: `rsp_*` stable throughout and `req_ready` stays 0.
  - After `rsp_ready` rises, requester 2 is granted in the cycle after the handshake.
- **Lock:** requesters 0 and 1 valid, `req_lock[0]`=1, for 3 operations.
  - With `WMUL_ARB_LOCK_EN`: ids 0,0,0.
  - Without `WMUL_ARB_LOCK_EN`: ids 0,1,0.
- **Reset mid-operation:** assert `rst_n`=0 in EXEC.
  - Response: no `rsp_valid`, all outputs at reset values, `op_count`=0.
  - The next request after reset is arbitrated from `rr_ptr`=0.
